// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frame parser for a 4-byte UART command protocol
// (HDR, CMD, DATA, CHK with CHK = CMD ^ DATA). It executes an LED write or
// read and answers through a busy/enable transmitter handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | hunting for the header byte, other bytes dropped silently
// W_CMD    | header seen, waiting for the command byte
// W_DATA   | waiting for the data byte
// W_CHK    | waiting for the checksum byte
// EXEC     | one cycle: validate, apply write, choose ACK/NAK
// TX_ACK   | sending the ACK/NAK byte (wait idle, pulse, guard)
// TX_RD    | sending the LED readback byte after the ACK
// TX_WAIT  | waiting for the transmitter to go idle before IDLE
module uart_cmd_parser #(
  parameter int          CLK_FREQ    = 50000000,
  parameter int          TIMEOUT_CYC = 500000,
  parameter logic [7:0]  HDR         = 8'h55
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic [3:0] led_reg,
  output logic       frame_err,
  output logic       parser_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_CMD   = 3'd1;
  localparam logic [2:0] S_W_DATA  = 3'd2;
  localparam logic [2:0] S_W_CHK   = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_TX_ACK  = 3'd5;
  localparam logic [2:0] S_TX_RD   = 3'd6;
  localparam logic [2:0] S_TX_WAIT = 3'd7;

  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  // Guard cycles after each tx_en while the transmitter raises tx_busy.
  localparam logic [2:0] GUARD = 3'd4;

  // A TIMEOUT_CYC of 0 falls back to a 10 ms gap derived from the clock.
  localparam int         GAP_LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC : (CLK_FREQ / 100);
  localparam logic [19:0] GAP_TC   = 20'(GAP_LIMIT - 1);

  logic [2:0]  state;
  logic [7:0]  cmd_q;
  logic [7:0]  data_q;
  logic [7:0]  chk_q;
  logic [19:0] gap_cnt;
  logic [2:0]  guard_cnt;
  logic        sent;
  logic        rd_pend;
  logic [7:0]  resp_q;

  logic        in_frame;
  logic        gap_tc;
  logic        chk_ok;
  logic        write_ok;
  logic [7:0]  exec_resp;
  logic        exec_err;
  logic        exec_rd;

  assign in_frame    = (state == S_W_CMD) || (state == S_W_DATA) || (state == S_W_CHK);
  assign gap_tc      = in_frame && (gap_cnt == GAP_TC);
  assign chk_ok      = ((cmd_q ^ data_q) == chk_q);
  assign write_ok    = chk_ok && (cmd_q == CMD_WR);
  assign parser_busy = (state != S_IDLE);

  // Response decision for the EXEC cycle; checksum failure outranks the command.
  always_comb begin
    exec_resp = NAK;
    exec_err  = 1'b1;
    exec_rd   = 1'b0;
    if (chk_ok) begin
      if (cmd_q == CMD_WR) begin
        exec_resp = ACK;
        exec_err  = 1'b0;
      end else if (cmd_q == CMD_RD) begin
        exec_resp = ACK;
        exec_err  = 1'b0;
        exec_rd   = 1'b1;
      end
    end
  end

  // Inter-byte gap counter: restarts on every byte, only runs inside a frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gap_cnt <= '0;
    end else if (rx_done || !in_frame) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 20'd1;
    end
  end

  // Main parser FSM with response handshake; tx_en and frame_err are pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      data_q    <= '0;
      chk_q     <= '0;
      guard_cnt <= '0;
      sent      <= 1'b0;
      rd_pend   <= 1'b0;
      resp_q    <= '0;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      led_reg   <= '0;
      frame_err <= 1'b0;
    end else begin
      tx_en     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_done && (rx_data == HDR)) state <= S_W_CMD;
        end
        S_W_CMD: begin
          if (rx_done) begin
            cmd_q <= rx_data;
            state <= S_W_DATA;
          end else if (gap_tc) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_W_DATA: begin
          if (rx_done) begin
            data_q <= rx_data;
            state  <= S_W_CHK;
          end else if (gap_tc) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_W_CHK: begin
          if (rx_done) begin
            chk_q <= rx_data;
            state <= S_EXEC;
          end else if (gap_tc) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_EXEC: begin
          resp_q    <= exec_resp;
          rd_pend   <= exec_rd;
          frame_err <= exec_err;
          if (write_ok) led_reg <= data_q[3:0];
          state <= S_TX_ACK;
          // Issuing straight from EXEC keeps the reply two cycles after CHK.
          if (!tx_busy) begin
            tx_en     <= 1'b1;
            tx_data   <= exec_resp;
            sent      <= 1'b1;
            guard_cnt <= GUARD;
          end else begin
            sent <= 1'b0;
          end
        end
        S_TX_ACK: begin
          if (!sent) begin
            if (!tx_busy) begin
              tx_en     <= 1'b1;
              tx_data   <= resp_q;
              sent      <= 1'b1;
              guard_cnt <= GUARD;
            end
          end else if (guard_cnt != 3'd0) begin
            guard_cnt <= guard_cnt - 3'd1;
          end else begin
            sent  <= 1'b0;
            state <= rd_pend ? S_TX_RD : S_TX_WAIT;
          end
        end
        S_TX_RD: begin
          if (!sent) begin
            if (!tx_busy) begin
              tx_en     <= 1'b1;
              tx_data   <= {4'h0, led_reg};
              sent      <= 1'b1;
              guard_cnt <= GUARD;
            end
          end else if (guard_cnt != 3'd0) begin
            guard_cnt <= guard_cnt - 3'd1;
          end else begin
            sent  <= 1'b0;
            state <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a small transmitter model that
// raises tx_busy two cycles after each tx_en and holds it for ten cycles.
module tb_uart_cmd_parser;

  localparam int TOUT = 64;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [3:0] led_reg;
  logic       frame_err;
  logic       parser_busy;

  int vectors;
  int miscompares;

  int       cyc;
  int       n_tx;
  int       n_err;
  logic [7:0] tx_log [0:63];
  int       tx_cyc_log [0:63];
  bit       hl_log [0:63];
  bit       seen_hi;
  bit       seen_hl;
  int       chk_cyc;

  uart_cmd_parser #(
    .CLK_FREQ    (50000000),
    .TIMEOUT_CYC (TOUT),
    .HDR         (8'h55)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .tx_busy     (tx_busy),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .led_reg     (led_reg),
    .frame_err   (frame_err),
    .parser_busy (parser_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Transmitter model
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_en) begin
        repeat (2) @(negedge sys_clk);
        tx_busy = 1'b1;
        repeat (10) @(negedge sys_clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Output monitor, sampled just after each rising edge
  initial begin
    cyc = 0; n_tx = 0; n_err = 0; seen_hi = 0; seen_hl = 0;
    forever begin
      @(posedge sys_clk);
      cyc = cyc + 1;
      #1;
      if (sys_rst_n) begin
        if (tx_busy) seen_hi = 1;
        else if (seen_hi) seen_hl = 1;
        if (tx_en && n_tx < 64) begin
          tx_log[n_tx]     = tx_data;
          tx_cyc_log[n_tx] = cyc;
          hl_log[n_tx]     = seen_hl;
          seen_hi = 0;
          seen_hl = 0;
          n_tx = n_tx + 1;
        end
        if (frame_err) n_err = n_err + 1;
      end
    end
  end

  // Caller sits at a falling edge; returns one falling edge later.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    chk_cyc = cyc;
    @(negedge sys_clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k;
    k = 0;
    while (parser_busy && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    ok = !parser_busy;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    idle(3);
    vectors++; if (tx_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    vectors++; if (led_reg !== 4'h0) begin miscompares++; $display("FAIL reset_led: got %h want 0", led_reg); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++; if (parser_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", parser_busy); end
    sys_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write;
    int tx0, er0;
    bit ok;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h05); send_byte(8'h04);
    wait_idle(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL write_done: busy still %b want 0", parser_busy); end
    vectors++; if (led_reg !== 4'h5) begin miscompares++; $display("FAIL write_led: got %h want 5", led_reg); end
    vectors++; if (n_tx - tx0 !== 1) begin miscompares++; $display("FAIL write_tx_count: got %0d want 1", n_tx - tx0); end
    vectors++; if (tx_log[tx0] !== 8'h06) begin miscompares++; $display("FAIL write_ack: got %h want 06", tx_log[tx0]); end
    vectors++; if (n_err - er0 !== 0) begin miscompares++; $display("FAIL write_err: got %0d want 0", n_err - er0); end
    vectors++; if (tx_cyc_log[tx0] - chk_cyc !== 2) begin miscompares++; $display("FAIL write_latency: got %0d want 2", tx_cyc_log[tx0] - chk_cyc); end
  endtask

  task automatic test_read;
    int tx0, er0;
    bit ok;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    wait_idle(300, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL read_done: busy still %b want 0", parser_busy); end
    vectors++; if (n_tx - tx0 !== 2) begin miscompares++; $display("FAIL read_tx_count: got %0d want 2", n_tx - tx0); end
    vectors++; if (tx_log[tx0] !== 8'h06) begin miscompares++; $display("FAIL read_ack: got %h want 06", tx_log[tx0]); end
    vectors++; if (tx_log[tx0+1] !== 8'h05) begin miscompares++; $display("FAIL read_byte: got %h want 05", tx_log[tx0+1]); end
    vectors++; if (hl_log[tx0+1] !== 1'b1) begin miscompares++; $display("FAIL read_handshake: busy high-then-low seen %b want 1", hl_log[tx0+1]); end
    vectors++; if (n_err - er0 !== 0) begin miscompares++; $display("FAIL read_err: got %0d want 0", n_err - er0); end
    vectors++; if (led_reg !== 4'h5) begin miscompares++; $display("FAIL read_led: got %h want 5", led_reg); end
  endtask

  task automatic test_bad_chk;
    int tx0, er0;
    bit ok;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h03); send_byte(8'h00);
    wait_idle(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL badchk_done: busy still %b want 0", parser_busy); end
    vectors++; if (n_err - er0 !== 1) begin miscompares++; $display("FAIL badchk_err: got %0d want 1", n_err - er0); end
    vectors++; if (n_tx - tx0 !== 1) begin miscompares++; $display("FAIL badchk_tx_count: got %0d want 1", n_tx - tx0); end
    vectors++; if (tx_data !== 8'h15) begin miscompares++; $display("FAIL badchk_nak: got %h want 15", tx_data); end
    vectors++; if (led_reg !== 4'h5) begin miscompares++; $display("FAIL badchk_led: got %h want 5", led_reg); end
  endtask

  task automatic test_timeout;
    int tx0, er0;
    bit ok;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h55); send_byte(8'h01);
    idle(TOUT + 2);
    vectors++; if (n_err - er0 !== 1) begin miscompares++; $display("FAIL timeout_err: got %0d want 1", n_err - er0); end
    vectors++; if (parser_busy !== 1'b0) begin miscompares++; $display("FAIL timeout_idle: busy %b want 0", parser_busy); end
    vectors++; if (n_tx - tx0 !== 0) begin miscompares++; $display("FAIL timeout_tx: got %0d want 0", n_tx - tx0); end
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h0A); send_byte(8'h0B);
    wait_idle(200, ok);
    vectors++; if (led_reg !== 4'hA) begin miscompares++; $display("FAIL timeout_next_led: got %h want A", led_reg); end
    vectors++; if (tx_data !== 8'h06) begin miscompares++; $display("FAIL timeout_next_ack: got %h want 06", tx_data); end
  endtask

  // Last byte lands exactly on the terminal-count cycle and must still count.
  task automatic test_gap_boundary;
    int tx0, er0;
    bit ok;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h55); send_byte(8'h01);
    idle(TOUT - 1);
    vectors++; if (parser_busy !== 1'b1) begin miscompares++; $display("FAIL gap_still_waiting: busy %b want 1", parser_busy); end
    send_byte(8'h0C); send_byte(8'h0D);
    wait_idle(200, ok);
    vectors++; if (n_err - er0 !== 0) begin miscompares++; $display("FAIL gap_err: got %0d want 0", n_err - er0); end
    vectors++; if (led_reg !== 4'hC) begin miscompares++; $display("FAIL gap_led: got %h want C", led_reg); end
    vectors++; if (n_tx - tx0 !== 1) begin miscompares++; $display("FAIL gap_tx_count: got %0d want 1", n_tx - tx0); end
  endtask

  task automatic test_hdr_skip;
    int tx0, er0;
    bit ok;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h12); send_byte(8'h34);
    vectors++; if (parser_busy !== 1'b0) begin miscompares++; $display("FAIL skip_idle: busy %b want 0", parser_busy); end
    send_byte(8'h55); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    wait_idle(200, ok);
    vectors++; if (n_err - er0 !== 1) begin miscompares++; $display("FAIL skip_err: got %0d want 1", n_err - er0); end
    vectors++; if (n_tx - tx0 !== 1) begin miscompares++; $display("FAIL skip_tx_count: got %0d want 1", n_tx - tx0); end
    vectors++; if (tx_log[tx0] !== 8'h15) begin miscompares++; $display("FAIL skip_nak: got %h want 15", tx_log[tx0]); end
    vectors++; if (led_reg !== 4'hC) begin miscompares++; $display("FAIL skip_led: got %h want C", led_reg); end
  endtask

  // A second frame sent while the first is being answered is dropped whole.
  task automatic test_back_to_back;
    int tx0, er0;
    bit ok;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h09); send_byte(8'h08);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h03); send_byte(8'h02);
    wait_idle(200, ok);
    idle(5);
    vectors++; if (parser_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: busy %b want 0", parser_busy); end
    vectors++; if (led_reg !== 4'h9) begin miscompares++; $display("FAIL b2b_led: got %h want 9", led_reg); end
    vectors++; if (n_tx - tx0 !== 1) begin miscompares++; $display("FAIL b2b_tx_count: got %0d want 1", n_tx - tx0); end
    vectors++; if (n_err - er0 !== 0) begin miscompares++; $display("FAIL b2b_err: got %0d want 0", n_err - er0); end
  endtask

  task automatic test_reset_mid;
    int tx0, er0;
    tx0 = n_tx; er0 = n_err;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h0F);
    sys_rst_n = 1'b0;
    #1;
    vectors++; if (parser_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", parser_busy); end
    vectors++; if (led_reg !== 4'h0) begin miscompares++; $display("FAIL rstmid_led: got %h want 0", led_reg); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
    vectors++; if (tx_en !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_pulses: tx_en %b frame_err %b want 0 0", tx_en, frame_err); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    send_byte(8'h0E);
    idle(30);
    vectors++; if (n_tx - tx0 !== 0) begin miscompares++; $display("FAIL rstmid_tx: got %0d want 0", n_tx - tx0); end
    vectors++; if (n_err - er0 !== 0) begin miscompares++; $display("FAIL rstmid_err: got %0d want 0", n_err - er0); end
    vectors++; if (led_reg !== 4'h0) begin miscompares++; $display("FAIL rstmid_led_after: got %h want 0", led_reg); end
    vectors++; if (parser_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: busy %b want 0", parser_busy); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    sys_rst_n = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    @(negedge sys_clk);
    test_reset;
    test_write;
    test_read;
    test_bad_chk;
    test_timeout;
    test_gap_boundary;
    test_hdr_skip;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 500000, meaning the maximum idle gap between frame bytes, in clocks (10 ms).
REQ-003 The block SHALL have parameter HDR, default 8'h55, meaning the frame header byte.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx_data, input, 8 bits: received byte, valid when rx_done=1.
REQ-007 The block SHALL have port rx_done, input, 1 bit: receiver byte strobe, taken as a one-cycle pulse.
REQ-008 The block SHALL have port tx_busy, input, 1 bit: the transmitter is sending.
REQ-009 The block SHALL have port tx_en, output, 1 bit: transmit request, a one-cycle pulse.
REQ-010 The block SHALL have port tx_data, output, 8 bits: the byte to transmit, held stable from the tx_en pulse until the next tx_en.
REQ-011 The block SHALL have port led_reg, output, 4 bits: LED control register.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a checksum, command or timeout error.
REQ-013 The block SHALL have port parser_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 A frame SHALL be 4 bytes in this order: HDR, CMD, DATA, CHK, where a valid CHK equals CMD XOR DATA.
REQ-015 The FSM SHALL have these states: IDLE, W_CMD, W_DATA, W_CHK, EXEC, TX_ACK, TX_RD, TX_WAIT.
REQ-016 In IDLE, rx_done with rx_data==HDR SHALL go to W_CMD; any other byte SHALL be discarded silently with no frame_err.
REQ-017 On rx_done, W_CMD SHALL latch CMD and go to W_DATA, W_DATA SHALL latch DATA and go to W_CHK, and W_CHK SHALL latch CHK and go to EXEC.
REQ-018 Gap counter, 20 bits: it SHALL clear on every rx_done and on entry to W_CMD, and SHALL count in W_CMD, W_DATA and W_CHK.
REQ-019 When the gap counter reaches TIMEOUT_CYC-1, the block SHALL pulse frame_err, go to IDLE and send no response.
REQ-020 EXEC SHALL last exactly 1 cycle and decide the response as follows:
- CHK mismatch -> response NAK 8'h15, frame_err pulse.
- CMD 8'h01 (write) -> led_reg <= DATA[3:0] on this cycle; response ACK 8'h06.
- CMD 8'h02 (read) -> response ACK 8'h06, then the byte {4'h0, led_reg}.
- Any other CMD -> response NAK 8'h15, frame_err pulse.
REQ-021 Every response byte SHALL be sent with one handshake: wait until tx_busy==0, then drive tx_data and pulse tx_en for one cycle, then spend 4 guard cycles (the transmitter's rising-edge detection delay) before sampling tx_busy again.
REQ-022 The second read byte SHALL be issued from TX_RD only after the ACK handshake has completed.
REQ-023 After the last response byte's guard cycles, the block SHALL wait in TX_WAIT for tx_busy==0 and then go to IDLE.
REQ-024 Latency: the ACK/NAK tx_en pulse SHALL assert 2 cycles after the rx_done carrying CHK, provided tx_busy==0.
REQ-025 rx_done arriving in EXEC, TX_ACK, TX_RD or TX_WAIT SHALL be ignored: the byte is dropped, no state change and no frame_err.
REQ-026 A header byte arriving mid-frame SHALL be treated as ordinary payload, with no resynchronisation.
REQ-027 If rx_done and the timeout terminal count fall in the same cycle, the byte SHALL be accepted and the timeout discarded.
REQ-028 led_reg SHALL change only in EXEC for a valid write frame.

Reset
REQ-029 Asserting sys_rst_n low at any time, including mid-frame or mid-response, SHALL force immediately: state=IDLE, tx_en=0, tx_data=8'h00, led_reg=4'h0, frame_err=0, parser_busy=0, gap counter=0, and all latched CMD, DATA and CHK cleared.
REQ-030 After reset release, no partial frame SHALL resume and no pending response SHALL be sent.

Verification
REQ-031 The bench SHALL check: bytes 55 01 05 04, tx_busy=0 -> led_reg=4'h5, exactly one tx_en with tx_data=8'h06, frame_err stays 0.
REQ-032 The bench SHALL check: after REQ-031, bytes 55 02 00 02 -> two tx_en pulses with tx_data 8'h06 then 8'h05; the second pulse only after tx_busy has gone high then low.
REQ-033 The bench SHALL check: bytes 55 01 03 00 (bad CHK) -> one frame_err pulse, tx_data=8'h15, led_reg unchanged.
REQ-034 The bench SHALL check: bytes 55 01, then silence for TIMEOUT_CYC cycles -> frame_err pulse, return to IDLE, no tx_en; next bytes 55 01 0A 0B -> led_reg=4'hA.
REQ-035 The bench SHALL check: bytes 12 34 55 07 00 07 -> the first two bytes are ignored, then NAK 8'h15 with a frame_err pulse.
REQ-036 The bench SHALL check: reset asserted after bytes 55 01 0F -> all outputs at reset values; then CHK byte 0E alone -> no response, led_reg=4'h0.
